// File: rtl/jk_op_scheduler.sv
// ============================================================================
// Module      : jk_op_scheduler
// Description : Round-robin scheduler that lets NREQ requesters apply JK
//               operations (hold/reset/set/toggle) to a masked WIDTH-bit
//               JK flip-flop bank through an IDLE/ARB/APPLY/DONE sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_op_scheduler #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [WIDTH*NREQ-1:0]   mask,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        j_out,
  output logic [WIDTH-1:0]        k_out,
  output logic [WIDTH-1:0]        q,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_APPLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [NREQ-1:0]   req_q;      // requests as seen at the previous edge
  logic [PW-1:0]     rr_ptr;     // first index searched by the arbiter
  logic [PW-1:0]     winner;     // requester owning the current operation
  logic [PW-1:0]     pick;       // round-robin choice from req_q
  logic [1:0]        op_l;       // latched {J,K} of the winner
  logic [WIDTH-1:0]  mask_l;     // latched mask of the winner

  // Round-robin search: first set request at or above rr_ptr, wrapping to 0.
  always_comb begin
    logic hit;
    int   idx;
    pick = '0;
    hit  = 1'b0;
    idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!hit && req_q[idx]) begin
        pick = PW'(idx);
        hit  = 1'b1;
      end
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    j_out     = '0;
    k_out     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req_q) state_nxt = S_ARB;
      end
      S_ARB: begin
        busy = 1'b1;
        gnt  = NREQ'(1) << winner;
        // A requester that gives up before commit loses the slot silently.
        state_nxt = req[winner] ? S_APPLY : S_IDLE;
      end
      S_APPLY: begin
        busy  = 1'b1;
        gnt   = NREQ'(1) << winner;
        j_out = {WIDTH{op_l[1]}} & mask_l;
        k_out = {WIDTH{op_l[0]}} & mask_l;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        gnt  = NREQ'(1) << winner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; clr aborts whatever is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request sampling, winner/operand capture and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      winner <= '0;
      op_l   <= '0;
      mask_l <= '0;
      rr_ptr <= '0;
    end else begin
      req_q <= req;
      if (!clr) begin
        if (state == S_IDLE && (|req_q)) winner <= pick;
        if (state == S_ARB) begin
          op_l   <= op[2*winner +: 2];
          mask_l <= mask[winner*WIDTH +: WIDTH];
        end
        // Pointer only advances on a completed operation.
        if (state == S_DONE) begin
          rr_ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
      end
    end
  end

  // JK bank: committed at the edge that ends APPLY; clr wins over the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (state == S_APPLY) begin
      q <= (j_out & ~q) | (~k_out & q);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_op_scheduler.sv
// ============================================================================
// Module      : tb_jk_op_scheduler
// Description : Self-checking bench for jk_op_scheduler (WIDTH=8, NREQ=4):
//               directed vector table, hand-written corner sequences and
//               randomized transactions against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_op_scheduler;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  clr;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      j_out;
  logic [WIDTH-1:0]      k_out;
  logic [WIDTH-1:0]      q;
  logic                  busy;
  logic                  done;

  int n_pass  = 0;
  int n_total = 0;

  jk_op_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .req   (req),
    .op    (op),
    .mask  (mask),
    .gnt   (gnt),
    .j_out (j_out),
    .k_out (k_out),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    req   = '0;
    op    = '0;
    mask  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full request/grant/done transaction; req dropped once done is seen.
  task automatic txn(input logic [3:0] r, input logic [7:0] o, input logic [31:0] m,
                     output logic [3:0] g, output int dc, output int gc, output int multi);
    @(negedge clk);
    req = r; op = o; mask = m;
    g = '0; dc = 0; gc = 0; multi = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (gnt != '0) begin g = gnt; gc++; end
      if ($countones(gnt) > 1) multi++;
      if (done) begin dc++; req = '0; end
    end
    req = '0;
  endtask

  // Reference model: round-robin choice and JK semantics at transaction level.
  function automatic int model_pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_q(input logic [7:0] cur, input logic [1:0] jk,
                                         input logic [7:0] m);
    case (jk)
      2'b10:   return cur | m;
      2'b01:   return cur & ~m;
      2'b11:   return cur ^ m;
      default: return cur;
    endcase
  endfunction

  typedef struct {
    bit          rst;
    logic [3:0]  r;
    logic [7:0]  o;
    logic [31:0] m;
    logic [3:0]  eg;
    logic [7:0]  eq;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [3:0] g;
    int dc, gc, multi;
    int mrr, w;
    logic [7:0] mq;
    logic [3:0] rr;
    logic [7:0] ro;
    logic [31:0] rm;

    rst_n = 1'b0; clr = 1'b0; req = '0; op = '0; mask = '0;

    vt[0] = '{1'b1, 4'b0001, 8'b00_00_00_10, 32'h0000_00FF, 4'b0001, 8'hFF};
    vt[1] = '{1'b0, 4'b0010, 8'b00_00_11_00, 32'h0000_0F00, 4'b0010, 8'hF0};
    vt[2] = '{1'b0, 4'b0010, 8'b00_00_01_00, 32'h0000_F000, 4'b0010, 8'h00};
    vt[3] = '{1'b1, 4'b1111, 8'b00_01_11_10, 32'hFF30_FF0F, 4'b0001, 8'h0F};
    vt[4] = '{1'b0, 4'b1111, 8'b00_01_11_10, 32'hFF30_FF0F, 4'b0010, 8'hF0};
    vt[5] = '{1'b0, 4'b1111, 8'b00_01_11_10, 32'hFF30_FF0F, 4'b0100, 8'hC0};
    vt[6] = '{1'b0, 4'b1111, 8'b00_01_11_10, 32'hFF30_FF0F, 4'b1000, 8'hC0};
    vt[7] = '{1'b0, 4'b0001, 8'b00_00_00_10, 32'h0000_000F, 4'b0001, 8'hCF};

    // Reset state
    #2;
    check("reset_q",    32'(q), 32'h0);
    check("reset_gnt",  32'(gnt), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    do_reset();

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      if (vt[i].rst) do_reset();
      txn(vt[i].r, vt[i].o, vt[i].m, g, dc, gc, multi);
      check($sformatf("vec%0d_gnt", i), 32'(g), 32'(vt[i].eg));
      check($sformatf("vec%0d_q", i), 32'(q), 32'(vt[i].eq));
      check($sformatf("vec%0d_done_pulses", i), 32'(dc), 32'd1);
      check($sformatf("vec%0d_gnt_cycles", i), 32'(gc), 32'd3);
      check($sformatf("vec%0d_onehot", i), 32'(multi), 32'd0);
    end

    // Latency: req before edge n -> gnt after n+1, drive in APPLY, q at n+3
    do_reset();
    @(negedge clk);
    req = 4'b0001; op = 8'b10; mask = 32'hFF;
    @(posedge clk); #1;
    check("lat_n_gnt", 32'(gnt), 32'h0);
    check("lat_n_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    check("lat_n1_gnt", 32'(gnt), 32'h1);
    check("lat_n1_j", 32'(j_out), 32'h0);
    @(posedge clk); #1;
    check("lat_n2_j", 32'(j_out), 32'hFF);
    check("lat_n2_k", 32'(k_out), 32'h00);
    check("lat_n2_q", 32'(q), 32'h00);
    check("lat_n2_done", 32'(done), 32'h0);
    @(posedge clk); #1;
    check("lat_n3_q", 32'(q), 32'hFF);
    check("lat_n3_done", 32'(done), 32'h1);
    check("lat_n3_gnt", 32'(gnt), 32'h1);
    check("lat_n3_j", 32'(j_out), 32'h0);
    req = '0;
    @(posedge clk); #1;
    check("lat_n4_done", 32'(done), 32'h0);
    check("lat_n4_busy", 32'(busy), 32'h0);
    check("lat_n4_gnt", 32'(gnt), 32'h0);

    // Request drop during ARB: no update, no done, pointer unchanged
    do_reset();
    txn(4'b0010, 8'b00_00_10_00, 32'h0000_3C00, g, dc, gc, multi);   // q=3C, ptr->2
    check("drop_setup_q", 32'(q), 32'h3C);
    @(negedge clk);
    req = 4'b0100; op = 8'b00_11_00_00; mask = 32'h00FF_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("drop_arb_gnt", 32'(gnt), 32'h4);
    req = '0;
    dc = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) dc++;
      if (c == 0) begin
        check("drop_idle_busy", 32'(busy), 32'h0);
        check("drop_idle_gnt", 32'(gnt), 32'h0);
      end
    end
    check("drop_q", 32'(q), 32'h3C);
    check("drop_no_done", 32'(dc), 32'd0);
    txn(4'b0110, 8'b00_01_00_00, 32'h0004_0000, g, dc, gc, multi);
    check("drop_ptr_kept_gnt", 32'(g), 32'h4);
    check("drop_ptr_kept_q", 32'(q), 32'h38);

    // clr during APPLY overrides the set and suppresses done
    do_reset();
    @(negedge clk);
    req = 4'b0001; op = 8'b10; mask = 32'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("clr_in_apply_j", 32'(j_out), 32'hFF);
    clr = 1'b1; req = '0;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_q", 32'(q), 32'h00);
    check("clr_done", 32'(done), 32'h0);
    check("clr_busy", 32'(busy), 32'h0);
    check("clr_gnt", 32'(gnt), 32'h0);
    txn(4'b0011, 8'b00_00_10_10, 32'h0000_F00F, g, dc, gc, multi);
    check("clr_ptr_kept_gnt", 32'(g), 32'h1);

    // Asynchronous reset mid-cycle during APPLY
    do_reset();
    txn(4'b0010, 8'b00_00_10_00, 32'h0000_3C00, g, dc, gc, multi);   // ptr->2
    @(negedge clk);
    req = 4'b0100; op = 8'b00_10_00_00; mask = 32'h00FF_0000;
    repeat (3) @(posedge clk);
    #1;
    check("arst_pre_j", 32'(j_out), 32'hFF);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_j", 32'(j_out), 32'h0);
    check("arst_k", 32'(k_out), 32'h0);
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_q", 32'(q), 32'h0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(4'b0101, 8'b00_10_00_10, 32'h0011_0022, g, dc, gc, multi);
    check("arst_first_gnt", 32'(g), 32'h1);
    check("arst_first_q", 32'(q), 32'h22);

    // Randomized transactions against the model
    do_reset();
    mrr = 0;
    mq  = '0;
    for (int t = 0; t < 40; t++) begin
      rr = 4'($urandom_range(1, 15));
      ro = 8'($urandom);
      rm = $urandom;
      w  = model_pick(rr, mrr);
      txn(rr, ro, rm, g, dc, gc, multi);
      mq  = model_q(mq, ro[2*w +: 2], rm[8*w +: 8]);
      mrr = (w + 1) % NREQ;
      check($sformatf("rnd%0d_gnt", t), 32'(g), 32'(4'b0001 << w));
      check($sformatf("rnd%0d_q", t), 32'(q), 32'(mq));
      check($sformatf("rnd%0d_done", t), 32'(dc), 32'd1);
      check($sformatf("rnd%0d_onehot", t), 32'(multi), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
